tlul_error_responder: RTL and testbench
=======================================

// Module: tlul_error_responder
// PURPOSE
//  Parametrised TL-UL default/error slave for unmapped address holes behind the crossbar.
//  - Accepts any A-channel request and answers every one with d_error=1, in order.
//  - Queues up to DEPTH outstanding requests.
//  - Inserts a programmable response delay.
//  - Returns correct TL-UL D opcodes and fixed error data.
// PARAMETERS
//  TL_AW      32          address width
//  TL_DW      32          data width
//  TL_AIW     8           source ID width
//  TL_DIW     1           sink ID width
//  TL_DBW     TL_DW>>3    byte-mask width
//  TL_SZW     $clog2($clog2(TL_DBW)+1)  size field width
//  DEPTH      4           outstanding-request queue depth, >=1 (need not be power of 2)
//  RESP_DELAY 0           idle cycles a head entry waits before d_valid, 0..255
//  ERR_DATA   32'hDEADBEEF  d_data value for AccessAckData error responses (TL_DW wide)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset: synchronous, active-high, single clock domain
//  a_valid    in   1       A request valid
//  a_ready    out  1       A request ready
//  a_opcode   in   3       A opcode
//  a_param    in   3       A param (ignored)
//  a_size     in   TL_SZW  A size
//  a_source   in   TL_AIW  A source ID
//  a_address  in   TL_AW   A address (used only with stats)
//  a_mask     in   TL_DBW  A mask (ignored)
//  a_data     in   TL_DW   A data (ignored)
//  d_valid    out  1       D response valid
//  d_ready    in   1       D response ready
//  d_opcode   out  3       D opcode
//  d_param    out  3       D param
//  d_size     out  TL_SZW  D size
//  d_source   out  TL_AIW  D source ID
//  d_sink     out  TL_DIW  D sink ID
//  d_data     out  TL_DW   D data
//  d_error    out  1       D error flag
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - Queue emptied, delay counter cleared.
//  - d_valid=0, a_ready=1 from the cycle after the reset edge.
//  - Reset mid-operation drops all pending responses silently.
//  - All d_* payload outputs read 0 while d_valid=0.
//  Handshakes:
//  - a_ack = a_valid & a_ready; d_ack = d_valid & d_ready.
//  - a_ready = !full. There is no bypass: when full, a_ready stays 0 even if d_ack occurs that cycle.
//  - Push and pop in the same cycle are both performed; count is unchanged.
//  Queue entry {opcode_is_get, size, source}:
//  - Circular read/write pointers wrapping at DEPTH-1 -> 0.
//  - Count register 0..DEPTH.
//  Delay counter, loaded with RESP_DELAY whenever an entry becomes head:
//  - Push into an empty queue.
//  - Pop that leaves entries behind, or pop with a simultaneous push into an otherwise empty queue.
//  - Decrements each cycle while nonzero and !empty.
//  - d_valid = !empty & (cnt==0).
//  - Latency a_ack -> d_valid for an idle block = RESP_DELAY+1 cycles.
//  Response payload, held stable while d_valid & !d_ready:
//  - d_opcode: 3'd1 (AccessAckData) if the request was Get (3'd4); 3'd0 (AccessAck) for all other opcodes.
//  - d_data: ERR_DATA for AccessAckData, else 0.
//  - d_size and d_source echo the request.
//  - d_param=0, d_sink=0, d_error=1.
//  Responses always return in request order.
// CONFIGURATION
//  TLUL_ERR_STATS_EN defined:
//  - Adds ports err_count out 32 and err_addr out TL_AW.
//  - On every a_ack: err_count increments, saturating at 32'hFFFFFFFF; err_addr <= a_address.
//  - Both reset to 0.
//  TLUL_ERR_STATS_EN undefined: these ports and registers are absent; all other behaviour is identical.
// TESTING
//  1. RESP_DELAY=0: Get src=0x12 size=2 at cycle t, d_ready=1
//     -> d_valid at t+1; d_opcode=1, d_data=0xDEADBEEF, d_source=0x12, d_size=2, d_error=1.
//  2. PutFull src=3 with d_ready=0 for 5 cycles
//     -> d_valid=1 held; d_opcode=0, d_data=0, d_source=3 stable; single d_ack when d_ready rises.
//  3. DEPTH=4, d_ready=0, five back-to-back requests src=1..5
//     -> a_ready=0 after 4th accept; 5th waits; released after d_ack; responses return src 1,2,3,4,5 in order.
//  4. RESP_DELAY=3, two Gets back-to-back, d_ready=1
//     -> first d_valid 4 cycles after its accept; second d_valid 4 cycles after first d_ack.
//  5. rst=1 with 3 entries queued -> d_valid=0, a_ready=1 next cycle; no stale responses afterwards.
//  6. TLUL_ERR_STATS_EN: 3 requests, last address 0x4000_0010 -> err_count=3, err_addr=0x40000010;
//     err_count forced to max stays at 32'hFFFFFFFF.

Source files
------------

// File: rtl/tlul_error_responder.sv
// ============================================================================
// Module      : tlul_error_responder
// Description : TL-UL default slave for unmapped holes. Every A request is
//               answered in order with d_error=1 after a programmable delay.
//               Optional statistics (err_count/err_addr) via TLUL_ERR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tlul_error_responder #(
    parameter int              TL_AW      = 32,
    parameter int              TL_DW      = 32,
    parameter int              TL_AIW     = 8,
    parameter int              TL_DIW     = 1,
    parameter int              TL_DBW     = TL_DW >> 3,
    parameter int              TL_SZW     = $clog2($clog2(TL_DBW) + 1),
    parameter int              DEPTH      = 4,
    parameter int              RESP_DELAY = 0,
    parameter logic [TL_DW-1:0] ERR_DATA  = TL_DW'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [TL_SZW-1:0] a_size,
    input  logic [TL_AIW-1:0] a_source,
    input  logic [TL_AW-1:0]  a_address,
    input  logic [TL_DBW-1:0] a_mask,
    input  logic [TL_DW-1:0]  a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [2:0]        d_param,
    output logic [TL_SZW-1:0] d_size,
    output logic [TL_AIW-1:0] d_source,
    output logic [TL_DIW-1:0] d_sink,
    output logic [TL_DW-1:0]  d_data,
    output logic              d_error
`ifdef TLUL_ERR_STATS_EN
    ,
    output logic [31:0]       err_count,
    output logic [TL_AW-1:0]  err_addr
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + TL_SZW + TL_AIW;
    localparam int DLY_W = 8;

    localparam logic [2:0]       OP_GET        = 3'd4;
    localparam logic [2:0]       OP_ACCESS_ACK = 3'd0;
    localparam logic [2:0]       OP_ACK_DATA   = 3'd1;
    localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [DLY_W-1:0] DLY_LOAD      = DLY_W'(RESP_DELAY);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DLY_W-1:0] dly_q, dly_d;

    logic              full;
    logic              empty;
    logic              a_ack;
    logic              d_ack;
    logic              load_dly;
    logic [ENT_W-1:0]  new_entry;
    logic [ENT_W-1:0]  head;
    logic              head_get;
    logic [TL_SZW-1:0] head_size;
    logic [TL_AIW-1:0] head_source;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        a_ready   = !full;
        d_valid   = !empty && (dly_q == '0);
        a_ack     = a_valid && !full;
        d_ack     = d_valid && d_ready;
        new_entry = {(a_opcode == OP_GET), a_size, a_source};

        mem_d = mem_q;
        if (a_ack) begin
            mem_d[wptr_q] = new_entry;
        end
        wptr_d = a_ack ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = d_ack ? ptr_inc(rptr_q) : rptr_q;

        count_d = count_q;
        case ({a_ack, d_ack})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh head restarts the delay; a same-cycle push behind a last pop also counts.
        load_dly = (a_ack && empty) || (d_ack && ((count_q > CNT_ONE) || a_ack));
        dly_d    = dly_q;
        if (load_dly) begin
            dly_d = DLY_LOAD;
        end else if ((dly_q != '0) && !empty) begin
            dly_d = dly_q - DLY_W'(1);
        end
    end

    always_comb begin
        head                               = mem_q[rptr_q];
        {head_get, head_size, head_source} = head;
        d_opcode = d_valid ? (head_get ? OP_ACK_DATA : OP_ACCESS_ACK) : 3'd0;
        d_data   = (d_valid && head_get) ? ERR_DATA : '0;
        d_size   = d_valid ? head_size : '0;
        d_source = d_valid ? head_source : '0;
        d_param  = 3'd0;
        d_sink   = '0;
        d_error  = d_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dly_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dly_q   <= dly_d;
        end
    end

`ifdef TLUL_ERR_STATS_EN
    logic [31:0]      err_count_q, err_count_d;
    logic [TL_AW-1:0] err_addr_q, err_addr_d;

    always_comb begin
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (a_ack) begin
            if (err_count_q != 32'hFFFF_FFFF) begin
                err_count_d = err_count_q + 32'd1;
            end
            err_addr_d = a_address;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

    logic unused_inputs;
    assign unused_inputs = ^{a_param, a_mask, a_data};
`else
    logic unused_inputs;
    assign unused_inputs = ^{a_param, a_mask, a_data, a_address};
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlul_error_responder.sv
// Bench for tlul_error_responder: two instances (DEPTH=4/delay 0, DEPTH=3/delay 3)
// checked cycle by cycle against a queue-and-timestamp reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_tlul_error_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        a_valid = 1'b0;
    logic        d_ready = 1'b0;
    logic [2:0]  a_opcode = 3'd0;
    logic [2:0]  a_param = 3'd0;
    logic [1:0]  a_size = 2'd0;
    logic [7:0]  a_source = 8'd0;
    logic [31:0] a_address = 32'd0;
    logic [3:0]  a_mask = 4'hF;
    logic [31:0] a_data = 32'd0;

    wire a_valid0 = a_valid & ~sel;
    wire a_valid3 = a_valid & sel;
    wire d_ready0 = d_ready & ~sel;
    wire d_ready3 = d_ready & sel;

    logic        a_ready0, a_ready3, d_valid0, d_valid3, d_error0, d_error3;
    logic [2:0]  d_opcode0, d_opcode3, d_param0, d_param3;
    logic [1:0]  d_size0, d_size3;
    logic [7:0]  d_source0, d_source3;
    logic [0:0]  d_sink0, d_sink3;
    logic [31:0] d_data0, d_data3;
`ifdef TLUL_ERR_STATS_EN
    logic [31:0] err_count0, err_count3, err_addr0, err_addr3;
`endif

    tlul_error_responder #(.DEPTH(4), .RESP_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .a_valid(a_valid0), .a_ready(a_ready0),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid0), .d_ready(d_ready0), .d_opcode(d_opcode0), .d_param(d_param0),
        .d_size(d_size0), .d_source(d_source0), .d_sink(d_sink0), .d_data(d_data0),
        .d_error(d_error0)
`ifdef TLUL_ERR_STATS_EN
        , .err_count(err_count0), .err_addr(err_addr0)
`endif
    );

    tlul_error_responder #(.DEPTH(3), .RESP_DELAY(3)) dut3 (
        .clk(clk), .rst(rst), .a_valid(a_valid3), .a_ready(a_ready3),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid3), .d_ready(d_ready3), .d_opcode(d_opcode3), .d_param(d_param3),
        .d_size(d_size3), .d_source(d_source3), .d_sink(d_sink3), .d_data(d_data3),
        .d_error(d_error3)
`ifdef TLUL_ERR_STATS_EN
        , .err_count(err_count3), .err_addr(err_addr3)
`endif
    );

    wire        o_a_ready  = sel ? a_ready3  : a_ready0;
    wire        o_d_valid  = sel ? d_valid3  : d_valid0;
    wire        o_d_error  = sel ? d_error3  : d_error0;
    wire [2:0]  o_d_opcode = sel ? d_opcode3 : d_opcode0;
    wire [2:0]  o_d_param  = sel ? d_param3  : d_param0;
    wire [1:0]  o_d_size   = sel ? d_size3   : d_size0;
    wire [7:0]  o_d_source = sel ? d_source3 : d_source0;
    wire [0:0]  o_d_sink   = sel ? d_sink3   : d_sink0;
    wire [31:0] o_d_data   = sel ? d_data3   : d_data0;

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] sz;
        logic [7:0] src;
    } rsp_t;

    rsp_t        exp_q[$];
    int          cyc = 0;
    int          head_time = 0;
    int          depth_m = 4;
    int          delay_m = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_err_count = 32'd0;
    logic [31:0] m_err_addr = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic select_dut(input logic s);
        sel     = s;
        depth_m = s ? 3 : 4;
        delay_m = s ? 3 : 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        d_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        head_time   = 0;
        m_err_count = 32'd0;
        m_err_addr  = 32'd0;
        cyc++;
        chk("reset_a_ready", 64'(o_a_ready), 64'd1);
        chk("reset_d_valid", 64'(o_d_valid), 64'd0);
    endtask

    // One clock cycle: compare outputs with the model, apply inputs, advance the model.
    task automatic step(input logic av, input logic [2:0] op, input logic [1:0] sz,
                        input logic [7:0] src, input logic [31:0] addr, input logic dr,
                        output logic acc);
        logic exp_ar, exp_dv, a_ack, d_ack;
        int   n0;
        exp_ar = (exp_q.size() < depth_m);
        exp_dv = (exp_q.size() > 0) && (cyc >= head_time);
        chk("a_ready", 64'(o_a_ready), 64'(exp_ar));
        chk("d_valid", 64'(o_d_valid), 64'(exp_dv));
        chk("d_error", 64'(o_d_error), 64'(exp_dv));
        chk("d_param", 64'(o_d_param), 64'd0);
        chk("d_sink", 64'(o_d_sink), 64'd0);
        if (exp_dv) begin
            chk("d_opcode", 64'(o_d_opcode), 64'(exp_q[0].op));
            chk("d_data", 64'(o_d_data), (exp_q[0].op == 3'd1) ? 64'hDEAD_BEEF : 64'd0);
            chk("d_size", 64'(o_d_size), 64'(exp_q[0].sz));
            chk("d_source", 64'(o_d_source), 64'(exp_q[0].src));
        end else begin
            chk("idle_payload", 64'({o_d_opcode, o_d_size, o_d_source, o_d_data}), 64'd0);
        end
`ifdef TLUL_ERR_STATS_EN
        if (!sel) begin
            chk("err_count", 64'(err_count0), 64'(m_err_count));
            chk("err_addr", 64'(err_addr0), 64'(m_err_addr));
        end
`endif
        a_valid   = av;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_data    = $urandom;
        a_mask    = 4'($urandom);
        a_param   = 3'($urandom);
        d_ready   = dr;
        a_ack = av && exp_ar;
        d_ack = exp_dv && dr;
        n0 = exp_q.size();
        if (d_ack) void'(exp_q.pop_front());
        if (a_ack) exp_q.push_back('{op: (op == 3'd4) ? 3'd1 : 3'd0, sz: sz, src: src});
        if ((exp_q.size() > 0) && ((n0 == 0) || d_ack)) head_time = cyc + 1 + delay_m;
        if (a_ack && !sel) begin
            if (m_err_count != 32'hFFFF_FFFF) m_err_count = m_err_count + 32'd1;
            m_err_addr = addr;
        end
        acc = a_ack;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic dr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, 8'd0, 32'd0, dr, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   tries;

        select_dut(1'b0);
        @(negedge clk);
        do_reset();

        // Get with zero delay: response on the following cycle.
        step(1'b1, 3'd4, 2'd2, 8'h12, 32'h0, 1'b1, acc);
        chk("t1_accept", 64'(acc), 64'd1);
        chk("t1_d_valid", 64'(o_d_valid), 64'd1);
        chk("t1_d_opcode", 64'(o_d_opcode), 64'd1);
        chk("t1_d_data", 64'(o_d_data), 64'hDEAD_BEEF);
        chk("t1_d_source", 64'(o_d_source), 64'h12);
        idle(2, 1'b1);

        // PutFull held under backpressure, then one handshake.
        step(1'b1, 3'd0, 2'd2, 8'h03, 32'h0, 1'b0, acc);
        idle(5, 1'b0);
        chk("t2_held_valid", 64'(o_d_valid), 64'd1);
        idle(1, 1'b1);
        idle(3, 1'b0);

        // Fill the DEPTH=4 queue; the fifth request waits for a pop.
        for (int s = 1; s <= 4; s++) begin
            step(1'b1, 3'd1, 2'd1, 8'(s), 32'h100 + 32'(s), 1'b0, acc);
            chk("t3_accept", 64'(acc), 64'd1);
        end
        chk("t3_full_a_ready", 64'(o_a_ready), 64'd0);
        step(1'b1, 3'd4, 2'd1, 8'd5, 32'h105, 1'b0, acc);
        chk("t3_fifth_blocked", 64'(acc), 64'd0);
        tries = 0;
        do begin
            step(1'b1, 3'd4, 2'd1, 8'd5, 32'h105, 1'b1, acc);
            tries++;
        end while (!acc && tries < 20);
        chk("t3_fifth_accepted", 64'(acc), 64'd1);
        idle(8, 1'b1);

        // Reset with three entries pending drops them.
        for (int s = 0; s < 3; s++) step(1'b1, 3'd4, 2'd0, 8'h40 + 8'(s), 32'h0, 1'b0, acc);
        do_reset();
        idle(6, 1'b1);

`ifdef TLUL_ERR_STATS_EN
        step(1'b1, 3'd4, 2'd2, 8'h01, 32'h4000_0000, 1'b1, acc);
        step(1'b1, 3'd0, 2'd2, 8'h02, 32'h4000_0008, 1'b1, acc);
        step(1'b1, 3'd1, 2'd2, 8'h03, 32'h4000_0010, 1'b1, acc);
        chk("t6_err_count", 64'(err_count0), 64'd3);
        chk("t6_err_addr", 64'(err_addr0), 64'h4000_0010);
        idle(4, 1'b1);
        force dut0.err_count_q = 32'hFFFF_FFFE;
        #1;
        release dut0.err_count_q;
        m_err_count = 32'hFFFF_FFFE;
        step(1'b1, 3'd4, 2'd0, 8'h07, 32'h4000_0020, 1'b1, acc);
        step(1'b1, 3'd4, 2'd0, 8'h08, 32'h4000_0024, 1'b1, acc);
        idle(1, 1'b1);
        chk("t6_err_count_sat", 64'(err_count0), 64'hFFFF_FFFF);
        idle(4, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 2)), 8'($urandom), $urandom,
                 1'($urandom_range(0, 99) < 55), acc);
        end

        // Switch to the DEPTH=3, RESP_DELAY=3 instance.
        do_reset();
        select_dut(1'b1);
        idle(1, 1'b1);
        step(1'b1, 3'd4, 2'd2, 8'hA1, 32'h0, 1'b1, acc);
        step(1'b1, 3'd4, 2'd2, 8'hA2, 32'h0, 1'b1, acc);
        idle(2, 1'b1);
        chk("t4_first_valid", 64'(o_d_valid), 64'd1);
        chk("t4_first_source", 64'(o_d_source), 64'hA1);
        idle(3, 1'b1);
        chk("t4_gap_valid", 64'(o_d_valid), 64'd0);
        idle(1, 1'b1);
        chk("t4_second_valid", 64'(o_d_valid), 64'd1);
        chk("t4_second_source", 64'(o_d_source), 64'hA2);
        idle(4, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 2)), 8'($urandom), $urandom,
                 1'($urandom_range(0, 99) < 60), acc);
        end
        idle(20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
